modulo_juiz_disparo: RTL and testbench

Shot referee for the 7x5 naval-battle board. Consumes the latched ship-position matrix and the player's confirmed attack coordinate, then decides hit / miss / repeat. Accumulates the hit and shot counts and the attack matrix that feeds the LED-matrix scan stage. Drives the `rgb_output` indicator and flags end of game.

---
 rtl/modulo_juiz_disparo.sv | 203 ++++++++++++++++++++
 tb/tb_modulo_juiz_disparo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_juiz_disparo.sv
// -----------------------------------------------------------------------------
// modulo_juiz_disparo
// Shot referee for the 7x5 naval-battle board. Takes the confirmed attack
// coordinate, classifies it as hit / miss / repeat against the ship matrix,
// keeps the hit and shot counts and the attack matrix, holds the result colour
// for SHOW_TICKS divider ticks and flags the end of the game.
//
// Optional build macro: JUIZ_REPEAT_PENALTY_EN
//   defined   -> a repeated shot also counts as a shot (and can cause a loss)
//   undefined -> a repeated shot only shows the repeat colour
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module modulo_juiz_disparo #(
    parameter int SHIP_CELLS = 6,
    parameter int MAX_SHOTS  = 20,
    parameter int SHOW_TICKS = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        tick,
    input  logic        fire,
    input  logic        new_game,
    input  logic [2:0]  col,
    input  logic [2:0]  lin,
    input  logic [34:0] ship_map,
    output logic [34:0] shot_map,
    output logic [1:0]  rgb_output,
    output logic [5:0]  hits,
    output logic [5:0]  shots,
    output logic        busy,
    output logic        game_over,
    output logic        win
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd2;
    localparam logic [1:0] S_OVER = 2'd3;

    localparam logic [1:0] RGB_OFF    = 2'b00;
    localparam logic [1:0] RGB_HIT    = 2'b01;
    localparam logic [1:0] RGB_MISS   = 2'b10;
    localparam logic [1:0] RGB_REPEAT = 2'b11;

    localparam int             TW        = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(SHOW_TICKS - 1);
    localparam logic [5:0]     HITS_MAX  = 6'(SHIP_CELLS);
    localparam logic [5:0]     SHOTS_MAX = 6'(MAX_SHOTS);

    logic [1:0]    state_q,    state_d;
    logic [2:0]    lin_q,      lin_d;
    logic [2:0]    col_q,      col_d;
    logic [34:0]   shot_map_q, shot_map_d;
    logic [5:0]    hits_q,     hits_d;
    logic [5:0]    shots_q,    shots_d;
    logic [1:0]    rgb_q,      rgb_d;
    logic          win_q,      win_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;

    logic [5:0]    cell_k;
    logic          coord_ok;

    // Board cell (lin, col) lives at bit 34 - 5*lin - col (row-major, MSB first).
    function automatic logic [5:0] cell_idx(input logic [2:0] l, input logic [2:0] c);
        logic [5:0] l6;
        logic [5:0] c6;
        l6 = {3'b000, l};
        c6 = {3'b000, c};
        return 6'd34 - ((l6 << 2) + l6) - c6;
    endfunction

    // Counter increment that sticks at its terminal value instead of wrapping.
    function automatic logic [5:0] sat_inc(input logic [5:0] v, input logic [5:0] lim);
        return (v >= lim) ? lim : v + 6'd1;
    endfunction

    assign cell_k   = cell_idx(lin_q, col_q);
    assign coord_ok = (col <= 3'd4) && (lin <= 3'd6);

    // Next-state and datapath decisions for the referee FSM.
    always_comb begin
        state_d    = state_q;
        lin_d      = lin_q;
        col_d      = col_q;
        shot_map_d = shot_map_q;
        hits_d     = hits_q;
        shots_d    = shots_q;
        rgb_d      = rgb_q;
        win_d      = win_q;
        tick_cnt_d = tick_cnt_q;

        case (state_q)
            S_IDLE: begin
                // Out-of-range coordinates are silently dropped.
                if (fire && coord_ok) begin
                    lin_d   = lin;
                    col_d   = col;
                    state_d = S_EVAL;
                end
            end

            S_EVAL: begin
                if (shot_map_q[cell_k]) begin
                    rgb_d = RGB_REPEAT;
`ifdef JUIZ_REPEAT_PENALTY_EN
                    shots_d = sat_inc(shots_q, SHOTS_MAX);
`endif
                end else if (ship_map[cell_k]) begin
                    shot_map_d[cell_k] = 1'b1;
                    hits_d             = sat_inc(hits_q, HITS_MAX);
                    shots_d            = sat_inc(shots_q, SHOTS_MAX);
                    rgb_d              = RGB_HIT;
                end else begin
                    shot_map_d[cell_k] = 1'b1;
                    shots_d            = sat_inc(shots_q, SHOTS_MAX);
                    rgb_d              = RGB_MISS;
                end
                // Ticks seen while evaluating do not shorten the display window.
                tick_cnt_d = '0;
                state_d    = S_SHOW;
            end

            S_SHOW: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        // Win takes precedence so a winning last shot is a win.
                        if (hits_q == HITS_MAX) begin
                            state_d = S_OVER;
                            win_d   = 1'b1;
                            rgb_d   = RGB_REPEAT;
                        end else if (shots_q == SHOTS_MAX) begin
                            state_d = S_OVER;
                            win_d   = 1'b0;
                            rgb_d   = RGB_REPEAT;
                        end else begin
                            state_d = S_IDLE;
                            rgb_d   = RGB_OFF;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end

            S_OVER: begin
                rgb_d = RGB_REPEAT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new game overrides anything else happening this cycle.
        if (new_game) begin
            state_d    = S_IDLE;
            lin_d      = '0;
            col_d      = '0;
            shot_map_d = '0;
            hits_d     = '0;
            shots_d    = '0;
            rgb_d      = RGB_OFF;
            win_d      = 1'b0;
            tick_cnt_d = '0;
        end
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            lin_q      <= '0;
            col_q      <= '0;
            shot_map_q <= '0;
            hits_q     <= '0;
            shots_q    <= '0;
            rgb_q      <= RGB_OFF;
            win_q      <= 1'b0;
            tick_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lin_q      <= lin_d;
            col_q      <= col_d;
            shot_map_q <= shot_map_d;
            hits_q     <= hits_d;
            shots_q    <= shots_d;
            rgb_q      <= rgb_d;
            win_q      <= win_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign shot_map   = shot_map_q;
    assign rgb_output = rgb_q;
    assign hits       = hits_q;
    assign shots      = shots_q;
    assign busy       = (state_q != S_IDLE);
    assign game_over  = (state_q == S_OVER);
    assign win        = win_q;

endmodule

// File: tb/tb_modulo_juiz_disparo.sv
// -----------------------------------------------------------------------------
// tb_modulo_juiz_disparo
// Directed bench for the shot referee. Each accepted shot pushes its expected
// result into a queue; a monitor pops and compares when the DUT enters the
// result-display state (second cycle of busy).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_modulo_juiz_disparo;

`ifdef JUIZ_REPEAT_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        tick = 1'b0;
    logic        fire = 1'b0;
    logic        new_game = 1'b0;
    logic [2:0]  col = 3'd0;
    logic [2:0]  lin = 3'd0;
    logic [34:0] ship_map = 35'h7_E000_0000;  // (0,0..4) and (1,0)
    logic [34:0] shot_map;
    logic [1:0]  rgb_output;
    logic [5:0]  hits;
    logic [5:0]  shots;
    logic        busy;
    logic        game_over;
    logic        win;

    typedef struct packed {
        logic [1:0]  rgb;
        logic [5:0]  hits;
        logic [5:0]  shots;
        logic [34:0] map;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          age = 0;
    logic [34:0] e_map = '0;

    modulo_juiz_disparo #(
        .SHIP_CELLS (6),
        .MAX_SHOTS  (20),
        .SHOW_TICKS (4)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .tick       (tick),
        .fire       (fire),
        .new_game   (new_game),
        .col        (col),
        .lin        (lin),
        .ship_map   (ship_map),
        .shot_map   (shot_map),
        .rgb_output (rgb_output),
        .hits       (hits),
        .shots      (shots),
        .busy       (busy),
        .game_over  (game_over),
        .win        (win)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic pulse_fire(input int l, input int c);
        @(negedge clk);
        fire = 1'b1;
        lin  = 3'(l);
        col  = 3'(c);
        @(negedge clk);
        fire = 1'b0;
    endtask

    // Issue a valid shot with hand-computed expected result.
    task automatic shoot(input int l, input int c, input logic [1:0] rgb,
                         input int h, input int s);
        exp_t e;
        if (rgb != 2'b11) e_map[34 - 5*l - c] = 1'b1;
        e.rgb   = rgb;
        e.hits  = 6'(h);
        e.shots = 6'(s);
        e.map   = e_map;
        exp_q.push_back(e);
        pulse_fire(l, c);
        repeat (2) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        e_map = '0;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_rgb"},   64'(rgb_output), 64'd0);
        chk({tag, "_hits"},  64'(hits),       64'd0);
        chk({tag, "_shots"}, 64'(shots),      64'd0);
        chk({tag, "_map"},   64'(shot_map),   64'd0);
        chk({tag, "_flags"}, 64'({busy, game_over, win}), 64'd0);
    endtask

    initial begin
        // Scoreboard monitor: result is visible on the second busy cycle.
        fork
            forever begin
                @(negedge clk);
                if (!busy) age = 0;
                else if (age < 3) age = age + 1;
                if (age == 2) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 64'(rgb_output), 64'hFFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("res_rgb",   64'(rgb_output), 64'(e.rgb));
                        chk("res_hits",  64'(hits),       64'(e.hits));
                        chk("res_shots", 64'(shots),      64'(e.shots));
                        chk("res_map",   64'(shot_map),   64'(e.map));
                    end
                end
            end
        join_none

        // Reset
        #1 clr = 1'b0;
        #20;
        chk_idle_reset("reset");
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk_idle_reset("after_release");

        // First hit at (0,0): shot_map must be exactly bit 34
        shoot(0, 0, 2'b01, 1, 1);
        chk("hit_map_literal", 64'(shot_map), 64'(35'h4_0000_0000));
        ticks(3);
        chk("show_3ticks_busy", 64'(busy), 64'd1);
        chk("show_3ticks_rgb", 64'(rgb_output), 64'd1);
        ticks(1);
        chk("show_done_busy", 64'(busy), 64'd0);
        chk("show_done_rgb", 64'(rgb_output), 64'd0);

        // Miss at (6,4) -> bit 0
        shoot(6, 4, 2'b10, 1, 2);
        chk("miss_bit0", 64'(shot_map[0]), 64'd1);
        ticks(4);
        chk("miss_idle_rgb", 64'(rgb_output), 64'd0);

        // Repeat at (6,4); a fire on a ship cell during SHOW must be dropped
        shoot(6, 4, 2'b11, 1, 2 + PEN);
        pulse_fire(1, 0);
        ticks(4);
        chk("drop_show_hits", 64'(hits), 64'd1);
        chk("drop_show_shots", 64'(shots), 64'(2 + PEN));
        chk("drop_show_map", 64'(shot_map), 64'(e_map));

        // Out-of-range coordinates are ignored
        pulse_fire(0, 5);
        repeat (2) @(negedge clk);
        chk("col5_busy", 64'(busy), 64'd0);
        pulse_fire(7, 0);
        repeat (2) @(negedge clk);
        chk("lin7_busy", 64'(busy), 64'd0);
        chk("oor_shots", 64'(shots), 64'(2 + PEN));
        chk("oor_map", 64'(shot_map), 64'(e_map));

        // Remaining five hits -> win
        shoot(0, 1, 2'b01, 2, 3 + PEN); ticks(4);
        shoot(0, 2, 2'b01, 3, 4 + PEN); ticks(4);
        shoot(0, 3, 2'b01, 4, 5 + PEN); ticks(4);
        shoot(0, 4, 2'b01, 5, 6 + PEN); ticks(4);
        shoot(1, 0, 2'b01, 6, 7 + PEN);
        ticks(3);
        chk("win_pre_over", 64'(game_over), 64'd0);
        ticks(1);
        chk("win_over", 64'({game_over, win, busy}), 64'b111);
        chk("win_rgb", 64'(rgb_output), 64'd3);
        pulse_fire(2, 2);
        repeat (2) @(negedge clk);
        chk("over_fire_shots", 64'(shots), 64'(7 + PEN));
        chk("over_fire_map", 64'(shot_map), 64'(e_map));

        // New game restores reset values on the next edge
        pulse_new_game();
        chk_idle_reset("new_game1");

        // 20 misses on cells bits 0..19 (lines 3..6, all water) -> loss
        for (int i = 0; i < 20; i++) begin
            shoot((34 - i) / 5, (34 - i) % 5, 2'b10, 0, i + 1);
            ticks(4);
        end
        chk("loss_over", 64'({game_over, win, busy}), 64'b101);
        chk("loss_rgb", 64'(rgb_output), 64'd3);
        chk("loss_shots", 64'(shots), 64'd20);
        pulse_new_game();
        chk_idle_reset("new_game2");

        // Asynchronous clear during SHOW
        shoot(6, 4, 2'b10, 0, 1);
        ticks(1);
        #2 clr = 1'b0;
        #1;
        chk_idle_reset("async_clr");
        @(negedge clk);
        clr = 1'b1;
        e_map = '0;
        shoot(2, 2, 2'b10, 0, 1);
        chk("post_clr_bit22", 64'(shot_map[22]), 64'd1);
        ticks(4);
        chk("post_clr_idle", 64'(busy), 64'd0);

        // new_game wins over a simultaneous fire
        @(negedge clk);
        new_game = 1'b1;
        fire     = 1'b1;
        lin      = 3'd3;
        col      = 3'd3;
        @(negedge clk);
        new_game = 1'b0;
        fire     = 1'b0;
        e_map    = '0;
        repeat (2) @(negedge clk);
        chk_idle_reset("ng_priority");

        repeat (4) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
